// File: rtl/urx_frame_dec.sv
// urx_frame_dec: assembles 5-byte command frames from the UART receive byte
// stream, verifies the additive checksum and presents the decoded fields to
// the command/register layer.
//
// Frame: HEAD, CMD, ADDR, DATA, CHK   with CHK = (CMD + ADDR + DATA) mod 256
//
// Ports:
//   clk_sys   in   system clock (100 MHz)
//   rst_n     in   asynchronous active-low reset
//   pluse_us  in   one-cycle pulse every microsecond
//   rx_data   in   [7:0] received byte, qualified by rx_vld
//   rx_vld    in   one-cycle byte strobe
//   cmd_type  out  [7:0] command byte of the last good frame
//   cmd_addr  out  [7:0] address byte of the last good frame
//   cmd_data  out  [7:0] data byte of the last good frame
//   cmd_vld   out  one-cycle strobe: good frame decoded
//   err_chk   out  one-cycle strobe: checksum mismatch
//   err_tmo   out  one-cycle strobe: inter-byte timeout, partial frame dropped
//   busy      out  a frame is partially received
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | hunting for HEAD, other bytes dropped
// S_CMD  | waiting for the command byte
// S_ADDR | waiting for the address byte
// S_DATA | waiting for the data byte
// S_CHK  | waiting for the checksum byte
module urx_frame_dec #(
  parameter logic [7:0]  HEAD       = 8'hA5,
  parameter logic [15:0] TIMEOUT_US = 16'd1000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] cmd_type,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       cmd_vld,
  output logic       err_chk,
  output logic       err_tmo,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t      state;
  logic [7:0]  t_cmd;
  logic [7:0]  t_addr;
  logic [7:0]  t_data;
  logic [15:0] tmo_cnt;
  logic [7:0]  chk_sum;
  logic        tmo_hit;

  assign chk_sum = t_cmd + t_addr + t_data;

  // Fires on the microsecond pulse that would bring the counter to
  // TIMEOUT_US, so err_tmo (registered) lands in the following cycle.
  // A byte arriving in the same cycle takes priority.
  assign tmo_hit = (state != S_IDLE) && !rx_vld && pluse_us &&
                   (tmo_cnt == TIMEOUT_US - 16'd1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      t_cmd    <= 8'h00;
      t_addr   <= 8'h00;
      t_data   <= 8'h00;
      tmo_cnt  <= 16'd0;
      cmd_type <= 8'h00;
      cmd_addr <= 8'h00;
      cmd_data <= 8'h00;
      cmd_vld  <= 1'b0;
      err_chk  <= 1'b0;
      err_tmo  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cmd_vld <= 1'b0;
      err_chk <= 1'b0;
      err_tmo <= 1'b0;

      if (state == S_IDLE || rx_vld || tmo_hit) begin
        tmo_cnt <= 16'd0;
      end else if (pluse_us) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (tmo_hit) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        err_tmo <= 1'b1;
      end else if (rx_vld) begin
        case (state)
          S_IDLE: begin
            if (rx_data == HEAD) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end
          end
          S_CMD: begin
            t_cmd <= rx_data;
            state <= S_ADDR;
          end
          S_ADDR: begin
            t_addr <= rx_data;
            state  <= S_DATA;
          end
          S_DATA: begin
            t_data <= rx_data;
            state  <= S_CHK;
          end
          S_CHK: begin
            if (rx_data == chk_sum) begin
              cmd_type <= t_cmd;
              cmd_addr <= t_addr;
              cmd_data <= t_data;
              cmd_vld  <= 1'b1;
            end else begin
              err_chk <= 1'b1;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urx_frame_dec.sv
module tb_urx_frame_dec;

  localparam logic [7:0] HEAD = 8'hA5;
  localparam int         TMO  = 1000;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pluse_us;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] cmd_type, cmd_addr, cmd_data;
  logic       cmd_vld, err_chk, err_tmo, busy;

  urx_frame_dec #(.HEAD(HEAD), .TIMEOUT_US(16'd1000)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .pluse_us(pluse_us),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .cmd_type(cmd_type),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_vld (cmd_vld),
    .err_chk (err_chk),
    .err_tmo (err_tmo),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model: current partial frame as a byte queue, idle time in us.
  logic [7:0] frame_q[$];
  int         gap_us;
  logic       m_vld, m_chk, m_tmo, m_busy;
  logic [7:0] m_type, m_addr, m_data;

  typedef struct {
    logic [0:6][7:0] b;
    int              n;
    int              gap;
    logic            e_vld;
    logic            e_chk;
    logic [7:0]      e_type;
    logic [7:0]      e_addr;
    logic [7:0]      e_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    gap_us = 0;
    m_vld = 0; m_chk = 0; m_tmo = 0; m_busy = 0;
    m_type = 8'h00; m_addr = 8'h00; m_data = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic p);
    int s;
    m_vld = 0; m_chk = 0; m_tmo = 0;
    if (v) begin
      gap_us = 0;
      if (frame_q.size() == 0) begin
        if (d == HEAD) frame_q.push_back(d);
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 5) begin
          s = (int'(frame_q[1]) + int'(frame_q[2]) + int'(frame_q[3])) % 256;
          if (s == int'(frame_q[4])) begin
            m_vld  = 1;
            m_type = frame_q[1];
            m_addr = frame_q[2];
            m_data = frame_q[3];
          end else begin
            m_chk = 1;
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() != 0 && p) begin
      gap_us++;
      if (gap_us == TMO) begin
        m_tmo = 1;
        frame_q.delete();
        gap_us = 0;
      end
    end
    m_busy = (frame_q.size() != 0);
  endtask

  task automatic check_all();
    chk("cmd_vld",  cmd_vld,  m_vld);
    chk("err_chk",  err_chk,  m_chk);
    chk("err_tmo",  err_tmo,  m_tmo);
    chk("busy",     busy,     m_busy);
    chk("cmd_type", cmd_type, m_type);
    chk("cmd_addr", cmd_addr, m_addr);
    chk("cmd_data", cmd_data, m_data);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p);
    rx_vld = v; rx_data = d; pluse_us = p;
    @(posedge clk_sys);
    model_step(v, d, p);
    #1;
    check_all();
    rx_vld = 1'b0; pluse_us = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle_us(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic rand_idle(input int maxc);
    int c;
    c = $urandom_range(0, maxc);
    for (int k = 0; k < c; k++) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    vecs[0] = '{b:{8'hA5,8'h01,8'h10,8'h3C,8'h4D,8'h00,8'h00}, n:5, gap:87,
                e_vld:1'b1, e_chk:1'b0, e_type:8'h01, e_addr:8'h10, e_data:8'h3C};
    vecs[1] = '{b:{8'hA5,8'h01,8'h10,8'h3C,8'h4E,8'h00,8'h00}, n:5, gap:3,
                e_vld:1'b0, e_chk:1'b1, e_type:8'h01, e_addr:8'h10, e_data:8'h3C};
    vecs[2] = '{b:{8'h00,8'hFF,8'hA5,8'hA5,8'h00,8'h00,8'hA5}, n:7, gap:2,
                e_vld:1'b1, e_chk:1'b0, e_type:8'hA5, e_addr:8'h00, e_data:8'h00};
    vecs[3] = '{b:{8'hA5,8'h02,8'h00,8'h01,8'h03,8'h00,8'h00}, n:5, gap:0,
                e_vld:1'b1, e_chk:1'b0, e_type:8'h02, e_addr:8'h00, e_data:8'h01};
    vecs[4] = '{b:{8'hA5,8'hFF,8'hFF,8'hFF,8'hFD,8'h00,8'h00}, n:5, gap:1,
                e_vld:1'b1, e_chk:1'b0, e_type:8'hFF, e_addr:8'hFF, e_data:8'hFF};
    vecs[5] = '{b:{8'hA5,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00}, n:5, gap:0,
                e_vld:1'b0, e_chk:1'b1, e_type:8'hFF, e_addr:8'hFF, e_data:8'hFF};

    rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; pluse_us = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check_all();
    rst_n = 1'b1;

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte(vecs[i].b[j]);
        if (j == vecs[i].n - 1) begin
          chk("vec_cmd_vld",  cmd_vld,  vecs[i].e_vld);
          chk("vec_err_chk",  err_chk,  vecs[i].e_chk);
          chk("vec_cmd_type", cmd_type, vecs[i].e_type);
          chk("vec_cmd_addr", cmd_addr, vecs[i].e_addr);
          chk("vec_cmd_data", cmd_data, vecs[i].e_data);
          chk("vec_busy",     busy,     1'b0);
        end else begin
          idle_us(vecs[i].gap);
        end
      end
      step(1'b0, 8'h00, 1'b0);
      chk("vec_strobe_1cyc", {cmd_vld, err_chk}, 2'b00);
    end

    // Timeout after A5,02
    send_byte(8'hA5);
    send_byte(8'h02);
    idle_us(TMO - 1);
    chk("tmo_early", err_tmo, 1'b0);
    chk("tmo_busy_early", busy, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("tmo_fire", err_tmo, 1'b1);
    chk("tmo_busy_drop", busy, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("tmo_once", err_tmo, 1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03);
    chk("tmo_next_vld", cmd_vld, 1'b1);
    chk("tmo_next_type", {cmd_type, cmd_addr, cmd_data}, 24'h020001);

    // Byte arriving in the exact timeout cycle
    send_byte(8'hA5);
    send_byte(8'h04);
    idle_us(TMO - 1);
    step(1'b1, 8'h05, 1'b1);
    chk("bnd_no_tmo", err_tmo, 1'b0);
    chk("bnd_busy", busy, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("bnd_no_tmo_next", err_tmo, 1'b0);
    send_byte(8'h06);
    send_byte(8'h0F);
    chk("bnd_vld", cmd_vld, 1'b1);
    chk("bnd_fields", {cmd_type, cmd_addr, cmd_data}, 24'h040506);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h08);
    rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_fields", {cmd_type, cmd_addr, cmd_data}, 24'h000000);
    chk("rst_strobes", {cmd_vld, err_chk, err_tmo}, 3'b000);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    send_byte(8'h09);
    send_byte(8'h00);
    chk("rst_ignored", busy, 1'b0);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h08); send_byte(8'h09); send_byte(8'h18);
    chk("rst_frame_vld", cmd_vld, 1'b1);
    chk("rst_frame_fields", {cmd_type, cmd_addr, cmd_data}, 24'h070809);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int kind;
      logic [7:0] c, a, d, s;
      kind = $urandom_range(0, 19);
      if (kind < 8 || kind == 19) begin
        c = 8'($urandom); a = 8'($urandom); d = 8'($urandom);
        s = c + a + d;
        if (kind == 19) s = s ^ 8'($urandom_range(1, 255));
        send_byte(HEAD); rand_idle(3);
        send_byte(c);    rand_idle(3);
        send_byte(a);    rand_idle(3);
        send_byte(d);    rand_idle(3);
        send_byte(s);    rand_idle(3);
      end else if (kind < 16) begin
        send_byte(($urandom_range(0, 3) == 0) ? HEAD : 8'($urandom));
        rand_idle(4);
      end else if (kind < 18) begin
        step(1'b1, 8'($urandom), 1'b1);
      end else begin
        idle_us($urandom_range(995, 1005));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
